// File: rtl/yapp_tx_pkg.sv
// Shared types and header helpers for the YAPP packet transmitter.
package yapp_tx_pkg;

    typedef enum logic [2:0] {
        FILL,
        CHECK,
        TX_HDR,
        TX_PAY,
        TX_PAR,
        GAP
    } tx_state_e;

    localparam int unsigned LEN_MSB = 7;
    localparam int unsigned LEN_LSB = 2;
    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned LEN_W   = LEN_MSB + 1 - ADDR_W;

    function automatic logic [LEN_W-1:0] hdr_len(input logic [7:0] hdr);
        return hdr[LEN_MSB:LEN_LSB];
    endfunction

endpackage

// File: rtl/yapp_tx_buf.sv
// Payload register file: synchronous write, combinational read.
module yapp_tx_buf #(
    parameter int unsigned DEPTH = 63,
    parameter int unsigned AW    = 6
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rd_data_c
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Addresses past the last entry only occur on lookahead reads that are never used.
    assign rd_data_c = (32'(raddr) < DEPTH) ? mem_q[raddr] : 8'h00;

endmodule

// File: rtl/yapp_pkt_tx.sv
// Buffers one YAPP packet from a valid/ready source, checks its length and
// replays it to the router with parity, honouring in_suspend per byte.
module yapp_pkt_tx
    import yapp_tx_pkg::*;
#(
    parameter int unsigned MAX_LEN = 63,
    parameter int unsigned IPG     = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    input  logic       bad_parity,
    output logic [7:0] in_data,
    output logic       in_data_vld,
    input  logic       in_suspend,
    output logic       pkt_sent,
    output logic       len_err,
    output logic       busy
);

    localparam int unsigned AW    = $clog2(MAX_LEN);
    localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);
    localparam int unsigned GAP_W = 4;

    tx_state_e        state_q, state_d;
    logic [7:0]       hdr_q, hdr_d;
    logic             badpar_q, badpar_d;
    logic [7:0]       parity_q, parity_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             hdr_seen_q, hdr_seen_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             s_ready_q, s_ready_d;
    logic [7:0]       in_data_q, in_data_d;
    logic             vld_q, vld_d;
    logic             pkt_sent_q, pkt_sent_d;
    logic             len_err_q, len_err_d;
    logic             busy_q, busy_d;

    logic             buf_we;
    logic [AW-1:0]    buf_waddr;
    logic [AW-1:0]    buf_raddr;
    logic [7:0]       buf_rdata;
    logic [LEN_W-1:0] len_c;
    logic [7:0]       par_out_c;
    logic             last_pay_c;
    logic             drop_c;

    yapp_tx_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clock     (clock),
        .we        (buf_we),
        .waddr     (buf_waddr),
        .wdata     (s_data),
        .raddr     (buf_raddr),
        .rd_data_c (buf_rdata)
    );

    assign len_c      = hdr_len(hdr_q);
    assign par_out_c  = badpar_q ? ~parity_q : parity_q;
    assign last_pay_c = (32'(idx_q) + 32'd1) == 32'(len_c);
    assign drop_c     = (len_c == '0) || (32'(count_q) != 32'(len_c)) || ovf_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= FILL;
            hdr_q      <= 8'h00;
            badpar_q   <= 1'b0;
            parity_q   <= 8'h00;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            hdr_seen_q <= 1'b0;
            idx_q      <= '0;
            gap_q      <= '0;
            s_ready_q  <= 1'b0;
            in_data_q  <= 8'h00;
            vld_q      <= 1'b0;
            pkt_sent_q <= 1'b0;
            len_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            badpar_q   <= badpar_d;
            parity_q   <= parity_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            hdr_seen_q <= hdr_seen_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            s_ready_q  <= s_ready_d;
            in_data_q  <= in_data_d;
            vld_q      <= vld_d;
            pkt_sent_q <= pkt_sent_d;
            len_err_q  <= len_err_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state and registered-output logic; bus values hold by default so
    // in_suspend simply leaves everything untouched.
    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        badpar_d   = badpar_q;
        parity_d   = parity_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        hdr_seen_d = hdr_seen_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        in_data_d  = in_data_q;
        vld_d      = vld_q;
        pkt_sent_d = 1'b0;
        len_err_d  = 1'b0;
        buf_we     = 1'b0;
        buf_waddr  = AW'(count_q);
        buf_raddr  = (state_q == TX_HDR) ? '0 : AW'(idx_q + AW'(1));

        case (state_q)
            FILL: begin
                if (s_valid && s_ready_q) begin
                    if (!hdr_seen_q) begin
                        hdr_d      = s_data;
                        badpar_d   = bad_parity;
                        parity_d   = s_data;
                        count_d    = '0;
                        ovf_d      = 1'b0;
                        hdr_seen_d = 1'b1;
                    end else if (32'(count_q) < MAX_LEN) begin
                        buf_we   = 1'b1;
                        parity_d = parity_q ^ s_data;
                        count_d  = count_q + CNT_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (s_last) begin
                        state_d    = CHECK;
                        hdr_seen_d = 1'b0;
                    end
                end
            end
            CHECK: begin
                if (drop_c) begin
                    len_err_d = 1'b1;
                    state_d   = FILL;
                end else begin
                    in_data_d = hdr_q;
                    vld_d     = 1'b1;
                    state_d   = TX_HDR;
                end
            end
            TX_HDR: begin
                if (!in_suspend) begin
                    idx_d     = '0;
                    in_data_d = buf_rdata;
                    state_d   = TX_PAY;
                end
            end
            TX_PAY: begin
                if (!in_suspend) begin
                    if (last_pay_c) begin
                        in_data_d = par_out_c;
                        state_d   = TX_PAR;
                    end else begin
                        idx_d     = idx_q + AW'(1);
                        in_data_d = buf_rdata;
                    end
                end
            end
            TX_PAR: begin
                if (!in_suspend) begin
                    pkt_sent_d = 1'b1;
                    vld_d      = 1'b0;
                    gap_d      = '0;
                    state_d    = GAP;
                end
            end
            GAP: begin
                if (32'(gap_q) == IPG - 1) begin
                    state_d = FILL;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = FILL;
        endcase

        s_ready_d = (state_d == FILL);
        busy_d    = !((state_d == FILL) && !hdr_seen_d);
    end

    assign s_ready     = s_ready_q;
    assign in_data     = in_data_q;
    assign in_data_vld = vld_q;
    assign pkt_sent    = pkt_sent_q;
    assign len_err     = len_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_yapp_pkt_tx.sv
// Directed bench for yapp_pkt_tx: expected bus bytes are queued as packets are
// sent and popped by a bus monitor on every transfer.
module tb_yapp_pkt_tx;

    localparam int unsigned MAX_LEN = 63;
    localparam int unsigned IPG     = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic       bad_parity;
    logic [7:0] in_data;
    logic       in_data_vld;
    logic       in_suspend;
    logic       pkt_sent;
    logic       len_err;
    logic       busy;

    yapp_pkt_tx #(
        .MAX_LEN (MAX_LEN),
        .IPG     (IPG)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .bad_parity  (bad_parity),
        .in_data     (in_data),
        .in_data_vld (in_data_vld),
        .in_suspend  (in_suspend),
        .pkt_sent    (pkt_sent),
        .len_err     (len_err),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    logic [7:0] exp_q[$];
    logic [7:0] pay[0:127];
    int tests    = 0;
    int fails    = 0;
    int pkt_cnt  = 0;
    int lerr_cnt = 0;
    int rise_cnt = 0;
    int run      = 0;
    int last_run = 0;
    logic vld_prev = 1'b0;

    // Bus monitor: every transfer pops one expected byte.
    always @(negedge clock) begin
        logic [7:0] exp_b;
        if (!reset) begin
            if (in_data_vld && !in_suspend) begin
                tests++;
                assert (exp_q.size() != 0) else begin
                    fails++;
                    $error("FAIL bus_extra observed=%02h expected=none", in_data);
                end
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    tests++;
                    assert (in_data === exp_b) else begin
                        fails++;
                        $error("FAIL bus_byte observed=%02h expected=%02h", in_data, exp_b);
                    end
                end
            end
            if (pkt_sent) pkt_cnt++;
            if (len_err) lerr_cnt++;
            if (in_data_vld && !vld_prev) rise_cnt++;
            if (in_data_vld) begin
                run++;
            end else if (vld_prev) begin
                last_run = run;
                run = 0;
            end
        end else begin
            run = 0;
        end
        vld_prev = in_data_vld;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clock); #1;
            if (s_ready && !busy) ok = 1'b1;
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_sent(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clock);
            if (pkt_sent) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    // Waits (bounded) at posedge+1 until the bus carries byte b.
    task automatic wait_bus(input string tag, input logic [7:0] b);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clock); #1;
            if (in_data_vld && in_data == b) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    // Drives header + pay[0..n-1]; ends at posedge+1 after the s_last acceptance.
    task automatic send_pkt(input logic [7:0] hdr, input int n, input logic bp, input logic expect_ok);
        logic [7:0] p;
        p = hdr;
        if (expect_ok) exp_q.push_back(hdr);
        s_valid    = 1'b1;
        s_data     = hdr;
        bad_parity = bp;
        s_last     = (n == 0);
        @(posedge clock); #1;
        bad_parity = 1'b0;
        for (int i = 0; i < n; i++) begin
            s_data = pay[i];
            s_last = (i == n - 1);
            p = p ^ pay[i];
            if (expect_ok) exp_q.push_back(pay[i]);
            @(posedge clock); #1;
        end
        if (expect_ok) exp_q.push_back(bp ? ~p : p);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
    endtask

    initial begin
        int p0, l0, r0;
        reset      = 1'b1;
        s_data     = 8'h00;
        s_valid    = 1'b0;
        s_last     = 1'b0;
        bad_parity = 1'b0;
        in_suspend = 1'b0;

        // Reset state
        #2;
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_in_data", 32'(in_data), 32'h00);
        check("rst_vld", 32'(in_data_vld), 32'd0);
        check("rst_pkt_sent", 32'(pkt_sent), 32'd0);
        check("rst_len_err", 32'(len_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        check("post_rst_ready", 32'(s_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Clean packet: latency, contiguous bytes, pkt_sent and gap
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        p0 = pkt_cnt;
        send_pkt(8'h0D, 3, 1'b0, 1'b1);
        check("clean_ready_lo", 32'(s_ready), 32'd0);
        @(negedge clock);
        check("clean_check_vld", 32'(in_data_vld), 32'd0);
        @(negedge clock);
        check("clean_hdr_vld", 32'(in_data_vld), 32'd1);
        check("clean_hdr_data", 32'(in_data), 32'h0D);
        wait_sent("clean_sent");
        check("clean_gap_vld", 32'(in_data_vld), 32'd0);
        check("clean_gap_busy", 32'(busy), 32'd1);
        for (int k = 1; k < int'(IPG); k++) begin
            @(negedge clock);
            check("clean_gap_busy_k", 32'(busy), 32'd1);
            check("clean_gap_vld_k", 32'(in_data_vld), 32'd0);
        end
        @(negedge clock);
        check("clean_gap_end", 32'(busy), 32'd0);
        check("clean_run", 32'(last_run), 32'd5);
        check("clean_q_empty", 32'(exp_q.size()), 32'd0);
        check("clean_pkt_cnt", 32'(pkt_cnt - p0), 32'd1);

        // Backpressure on the 8'h22 byte for three cycles
        wait_idle("bp_idle");
        p0 = pkt_cnt;
        send_pkt(8'h0D, 3, 1'b0, 1'b1);
        wait_bus("bp_find22", 8'h22);
        in_suspend = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
            check("bp_hold_data", 32'(in_data), 32'h22);
            check("bp_hold_vld", 32'(in_data_vld), 32'd1);
        end
        in_suspend = 1'b0;
        wait_sent("bp_sent");
        repeat (2) @(negedge clock);
        check("bp_run", 32'(last_run), 32'd8);
        check("bp_q_empty", 32'(exp_q.size()), 32'd0);
        check("bp_pkt_cnt", 32'(pkt_cnt - p0), 32'd1);

        // Length mismatch: len 4, two payload bytes
        wait_idle("mm_idle");
        l0 = lerr_cnt; r0 = rise_cnt;
        pay[0] = 8'h01; pay[1] = 8'h02;
        send_pkt(8'h10, 2, 1'b0, 1'b0);
        @(negedge clock);
        check("mm_ready_lo", 32'(s_ready), 32'd0);
        @(negedge clock);
        check("mm_ready_hi", 32'(s_ready), 32'd1);
        check("mm_len_err", 32'(len_err), 32'd1);
        @(negedge clock);
        check("mm_len_err_pulse", 32'(len_err), 32'd0);
        repeat (8) @(negedge clock);
        check("mm_err_cnt", 32'(lerr_cnt - l0), 32'd1);
        check("mm_no_vld", 32'(rise_cnt - r0), 32'd0);

        // Overflow: header len 63, 65 payload bytes
        wait_idle("ovf_idle");
        l0 = lerr_cnt; r0 = rise_cnt;
        for (int i = 0; i < 65; i++) pay[i] = 8'(i + 3);
        send_pkt(8'hFD, 65, 1'b0, 1'b0);
        repeat (6) @(negedge clock);
        check("ovf_err_cnt", 32'(lerr_cnt - l0), 32'd1);
        check("ovf_no_vld", 32'(rise_cnt - r0), 32'd0);

        // Zero-length header-only packet
        wait_idle("zero_idle");
        l0 = lerr_cnt; r0 = rise_cnt;
        send_pkt(8'h02, 0, 1'b0, 1'b0);
        repeat (6) @(negedge clock);
        check("zero_err_cnt", 32'(lerr_cnt - l0), 32'd1);
        check("zero_no_vld", 32'(rise_cnt - r0), 32'd0);

        // Full-depth packet: len 63 exactly fills the buffer
        wait_idle("full_idle");
        p0 = pkt_cnt; l0 = lerr_cnt;
        for (int i = 0; i < 63; i++) pay[i] = 8'($urandom_range(0, 255));
        send_pkt(8'hFC, 63, 1'b0, 1'b1);
        wait_sent("full_sent");
        repeat (2) @(negedge clock);
        check("full_run", 32'(last_run), 32'd65);
        check("full_q_empty", 32'(exp_q.size()), 32'd0);
        check("full_no_err", 32'(lerr_cnt - l0), 32'd0);

        // Bad parity with suspend held on the parity byte
        wait_idle("bpar_idle");
        p0 = pkt_cnt;
        pay[0] = 8'hAA;
        send_pkt(8'h05, 1, 1'b1, 1'b1);
        wait_bus("bpar_find_par", 8'h50);
        in_suspend = 1'b1;
        repeat (2) begin
            @(posedge clock); #1;
            check("bpar_hold_data", 32'(in_data), 32'h50);
            check("bpar_no_sent", 32'(pkt_sent), 32'd0);
        end
        in_suspend = 1'b0;
        wait_sent("bpar_sent");
        repeat (2) @(negedge clock);
        check("bpar_q_empty", 32'(exp_q.size()), 32'd0);
        check("bpar_pkt_cnt", 32'(pkt_cnt - p0), 32'd1);

        // Asynchronous reset during payload, then a fresh packet with addr 3
        wait_idle("rst_idle");
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
        send_pkt(8'h11, 4, 1'b0, 1'b1);
        wait_bus("rst_find02", 8'h02);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_vld", 32'(in_data_vld), 32'd0);
        check("rst_mid_data", 32'(in_data), 32'h00);
        check("rst_mid_ready", 32'(s_ready), 32'd0);
        exp_q.delete();
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        check("rst_rel_ready", 32'(s_ready), 32'd1);
        p0 = pkt_cnt;
        pay[0] = 8'h5A; pay[1] = 8'hA5;
        send_pkt(8'h0B, 2, 1'b0, 1'b1);
        wait_sent("rst_fresh_sent");
        repeat (2) @(negedge clock);
        check("rst_fresh_run", 32'(last_run), 32'd4);
        check("rst_fresh_q_empty", 32'(exp_q.size()), 32'd0);
        check("rst_fresh_pkt_cnt", 32'(pkt_cnt - p0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
